retire_trace_monitor: RTL and testbench

//   Consumes the retire interface of the single-cycle core (i_insn_vld, i_pc_debug) in the simulation bench.

---
 rtl/retire_trace_monitor.sv | 180 ++++++++++++++++++
 tb/tb_retire_trace_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_monitor.sv
// Retire trace monitor: buffers retired PCs in a show-ahead FIFO, counts retirements, and flags
// program end on a self-loop. Optional PC range checking is enabled by defining PC_RANGE_CHECK_EN.
module retire_trace_monitor #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 8,
    parameter logic [31:0] PC_LO       = 32'h0000_0000,
    parameter logic [31:0] PC_HI       = 32'h0000_1FFC
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic [31:0] i_pc_debug,
    input  logic        i_rd_en,
    output logic        o_rd_vld,
    output logic [31:0] o_rd_pc,
    output logic        o_full,
    output logic        o_overflow,
    output logic [31:0] o_retire_cnt,
    output logic        o_halt,
    output logic        o_pc_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RW = $clog2(HALT_CYCLES + 1);
    localparam logic [RW-1:0] HALT_MATCH = RW'(HALT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [31:0]    mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [RW-1:0]  run_cnt_r;
    logic [RW-1:0]  run_next_s;
    logic [31:0]    last_pc_r;
    logic           overflow_r;
    logic           halt_r;
    logic           pc_err_r;
    logic [31:0]    retire_cnt_r;
    logic           accept_s;
    logic           empty_s;
    logic           full_s;
    logic           pop_s;
    logic           push_s;
    logic           halt_hit_s;
    logic           pc_bad_s;
    logic           halt_set_s;
    logic           ovf_set_s;

    assign accept_s   = i_insn_vld && (state_r != ST_HALTED);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s      = i_rd_en && !empty_s;
    assign push_s     = accept_s && (!full_s || pop_s);
    assign run_next_s = ((i_pc_debug == last_pc_r) && (run_cnt_r != {RW{1'b0}}))
                        ? (run_cnt_r + {{(RW-1){1'b0}}, 1'b1}) : {{(RW-1){1'b0}}, 1'b1};
    assign halt_hit_s = accept_s && (run_next_s == HALT_MATCH);

`ifdef PC_RANGE_CHECK_EN
    assign pc_bad_s = accept_s && ((i_pc_debug < PC_LO) || (i_pc_debug > PC_HI) ||
                                   (i_pc_debug[1:0] != 2'b00));
`else
    logic pc_range_unused_s;
    assign pc_range_unused_s = ^{PC_LO, PC_HI};
    assign pc_bad_s          = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an out-of-range first retire may halt straight from IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pc_bad_s) begin
                    state_next_s = ST_HALTED;
                end else if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_hit_s || pc_bad_s) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Output strobes that set the sticky status flags
    always_comb begin
        halt_set_s = 1'b0;
        ovf_set_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                halt_set_s = halt_hit_s || pc_bad_s;
                ovf_set_s  = accept_s && full_s && !pop_s;
            end
            ST_HALTED: begin
                halt_set_s = 1'b0;
                ovf_set_s  = 1'b0;
            end
            default: begin
                halt_set_s = 1'b0;
                ovf_set_s  = 1'b0;
            end
        endcase
    end

    // FIFO storage; stale contents are harmless because pointers reset
    always_ff @(posedge i_clk) begin
        if (push_s && !i_reset) begin
            mem_r[wr_ptr_r[AW-1:0]] <= i_pc_debug;
        end
    end

    // FIFO pointers, run tracking, counters and sticky flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            run_cnt_r    <= {RW{1'b0}};
            last_pc_r    <= 32'h0000_0000;
            retire_cnt_r <= 32'h0000_0000;
            overflow_r   <= 1'b0;
            halt_r       <= 1'b0;
            pc_err_r     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (accept_s) begin
                run_cnt_r <= run_next_s;
                last_pc_r <= i_pc_debug;
                if (retire_cnt_r != 32'hFFFF_FFFF) begin
                    retire_cnt_r <= retire_cnt_r + 32'h0000_0001;
                end
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
            if (halt_set_s) begin
                halt_r <= 1'b1;
            end
            if (pc_bad_s) begin
                pc_err_r <= 1'b1;
            end
        end
    end

    assign o_rd_vld     = !empty_s;
    assign o_rd_pc      = empty_s ? 32'h0000_0000 : mem_r[rd_ptr_r[AW-1:0]];
    assign o_full       = full_s;
    assign o_overflow   = overflow_r;
    assign o_retire_cnt = retire_cnt_r;
    assign o_halt       = halt_r;
    assign o_pc_err     = pc_err_r;

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed self-checking bench for retire_trace_monitor (DEPTH=16, HALT_CYCLES=8).
module tb_retire_trace_monitor;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_insn_vld = 1'b0;
    logic [31:0] i_pc_debug = 32'h0;
    logic        i_rd_en = 1'b0;
    logic        o_rd_vld;
    logic [31:0] o_rd_pc;
    logic        o_full;
    logic        o_overflow;
    logic [31:0] o_retire_cnt;
    logic        o_halt;
    logic        o_pc_err;

    int checks = 0;
    int failures = 0;

    retire_trace_monitor #(.DEPTH(16), .HALT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_insn_vld(i_insn_vld), .i_pc_debug(i_pc_debug),
        .i_rd_en(i_rd_en), .o_rd_vld(o_rd_vld), .o_rd_pc(o_rd_pc), .o_full(o_full),
        .o_overflow(o_overflow), .o_retire_cnt(o_retire_cnt), .o_halt(o_halt), .o_pc_err(o_pc_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_insn_vld = 1'b0; i_rd_en = 1'b0;
        step();
        i_reset = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc);
        i_insn_vld = 1'b1; i_pc_debug = pc;
        step();
        i_insn_vld = 1'b0;
    endtask

    task automatic pop();
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_insn_vld = 1'b1; i_pc_debug = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({o_rd_vld, o_full, o_overflow, o_halt, o_pc_err} !== 5'b0) begin
                failures++;
                $display("FAIL reset_flags cycle=%0d got=%b want=00000", i,
                         {o_rd_vld, o_full, o_overflow, o_halt, o_pc_err});
            end
            checks++;
            if (o_retire_cnt !== 32'h0 || o_rd_pc !== 32'h0) begin
                failures++;
                $display("FAIL reset_data cycle=%0d cnt=%0d pc=%h want 0", i, o_retire_cnt, o_rd_pc);
            end
        end
        i_reset = 1'b0;
        retire(32'h0000_0010);
        checks++;
        if (o_retire_cnt !== 32'd1 || o_rd_vld !== 1'b1 || o_rd_pc !== 32'h10) begin
            failures++;
            $display("FAIL reset_first_retire cnt=%0d vld=%b pc=%h want 1/1/10", o_retire_cnt, o_rd_vld, o_rd_pc);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) retire(32'(i * 4));
        checks++;
        if (o_retire_cnt !== 32'd8) begin
            failures++;
            $display("FAIL stream_cnt got=%0d want=8", o_retire_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_rd_vld !== 1'b1 || o_rd_pc !== 32'(i * 4)) begin
                failures++;
                $display("FAIL stream_head idx=%0d vld=%b pc=%h want 1/%h", i, o_rd_vld, o_rd_pc, i * 4);
            end
            pop();
        end
        checks++;
        if (o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL stream_drained vld=%b want=0", o_rd_vld);
        end
        pop();
        checks++;
        if (o_rd_vld !== 1'b0 || o_full !== 1'b0) begin
            failures++;
            $display("FAIL stream_pop_empty vld=%b full=%b want 0/0", o_rd_vld, o_full);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) retire(32'h1000 + 32'(i * 4));
        checks++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full16 full=%b ovf=%b want 1/0", o_full, o_overflow);
        end
        retire(32'h1040);
        checks++;
        if (o_overflow !== 1'b1 || o_retire_cnt !== 32'd17 || o_rd_pc !== 32'h1000 || o_halt !== 1'b0) begin
            failures++;
            $display("FAIL ovf_17th ovf=%b cnt=%0d head=%h halt=%b want 1/17/1000/0",
                     o_overflow, o_retire_cnt, o_rd_pc, o_halt);
        end
        pop();
        checks++;
        if (o_overflow !== 1'b1 || o_rd_pc !== 32'h1004 || o_full !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky ovf=%b head=%h full=%b want 1/1004/0", o_overflow, o_rd_pc, o_full);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 16; i++) retire(32'h100 + 32'(i * 4));
        i_insn_vld = 1'b1; i_pc_debug = 32'h200; i_rd_en = 1'b1;
        step();
        i_insn_vld = 1'b0; i_rd_en = 1'b0;
        checks++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0 || o_rd_pc !== 32'h104 || o_retire_cnt !== 32'd17) begin
            failures++;
            $display("FAIL fullpop_state full=%b ovf=%b head=%h cnt=%0d want 1/0/104/17",
                     o_full, o_overflow, o_rd_pc, o_retire_cnt);
        end
        for (int i = 0; i < 15; i++) pop();
        checks++;
        if (o_rd_vld !== 1'b1 || o_rd_pc !== 32'h200) begin
            failures++;
            $display("FAIL fullpop_tail vld=%b pc=%h want 1/200", o_rd_vld, o_rd_pc);
        end
        pop();
        checks++;
        if (o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_empty vld=%b want=0", o_rd_vld);
        end
        // Push and pop on an empty FIFO: only the push takes effect
        i_insn_vld = 1'b1; i_pc_debug = 32'h300; i_rd_en = 1'b1;
        step();
        i_insn_vld = 1'b0; i_rd_en = 1'b0;
        checks++;
        if (o_rd_vld !== 1'b1 || o_rd_pc !== 32'h300) begin
            failures++;
            $display("FAIL empty_pushpop vld=%b pc=%h want 1/300", o_rd_vld, o_rd_pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        retire(32'h40);
        for (int i = 0; i < 7; i++) retire(32'h44);
        checks++;
        if (o_halt !== 1'b0) begin
            failures++;
            $display("FAIL halt_early halt=%b want=0 after 7 repeats", o_halt);
        end
        retire(32'h44);
        checks++;
        if (o_halt !== 1'b1 || o_retire_cnt !== 32'd9) begin
            failures++;
            $display("FAIL halt_set halt=%b cnt=%0d want 1/9", o_halt, o_retire_cnt);
        end
        retire(32'h48);
        retire(32'h4C);
        checks++;
        if (o_retire_cnt !== 32'd9 || o_halt !== 1'b1) begin
            failures++;
            $display("FAIL halt_ignore cnt=%0d halt=%b want 9/1", o_retire_cnt, o_halt);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (o_rd_vld !== 1'b1 || o_rd_pc !== ((i == 0) ? 32'h40 : 32'h44)) begin
                failures++;
                $display("FAIL halt_drain idx=%0d vld=%b pc=%h", i, o_rd_vld, o_rd_pc);
            end
            pop();
        end
        checks++;
        if (o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL halt_drained vld=%b want=0", o_rd_vld);
        end
    endtask

    task automatic test_pc_range();
        logic exp_err;
        do_reset();
`ifdef PC_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        retire(32'h2000);
        checks++;
        if (o_pc_err !== exp_err || o_halt !== exp_err) begin
            failures++;
            $display("FAIL pc_range err=%b halt=%b want %b/%b", o_pc_err, o_halt, exp_err, exp_err);
        end
        checks++;
        if (o_rd_vld !== 1'b1 || o_rd_pc !== 32'h2000 || o_retire_cnt !== 32'd1) begin
            failures++;
            $display("FAIL pc_range_push vld=%b pc=%h cnt=%0d want 1/2000/1", o_rd_vld, o_rd_pc, o_retire_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_pop();
        test_halt();
        test_pc_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
